// File: rtl/beamsum_ctrl.sv
// Sequencer for the 4-lane weighted beam sum: lane join, adder-pipe stall, output valid/last, double-buffered weights.
// Fire-to-m_tvalid latency is ADD_LAT cycles; a stalled output (m_tready_i low with valid) freezes the pipe and drops s_tready.
module beamsum_ctrl #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int ADD_LAT      = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      en_i,
    input  logic [3:0]                s_tvalid_i,
    input  logic [3:0]                s_tlast_i,
    output logic [3:0]                s_tready_o,
    output logic                      sum_fire_o,
    output logic                      pipe_ce_o,
    output logic                      m_tvalid_o,
    output logic                      m_tlast_o,
    input  logic                      m_tready_i,
    input  logic                      cfg_wr_i,
    input  logic [2:0]                cfg_addr_i,
    input  logic [WEIGHT_WIDTH-1:0]   cfg_data_i,
    input  logic                      cfg_commit_i,
    output logic [8*WEIGHT_WIDTH-1:0] w_active_o,
    output logic                      commit_pend_o,
    output logic                      err_o,
    input  logic                      err_clr_i,
    output logic [CNT_WIDTH-1:0]      beat_cnt_o,
    output logic [CNT_WIDTH-1:0]      frame_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                                state_q, state_d;
    logic [ADD_LAT-1:0]                    vld_q, vld_d;
    logic [ADD_LAT-1:0]                    lst_q, lst_d;
    logic [CNT_WIDTH-1:0]                  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]                  frame_cnt_q, frame_cnt_d;
    logic                                  err_q, err_d;
    logic                                  commit_pend_q, commit_pend_d;
    logic                                  wt_loaded_q, wt_loaded_d;
    logic [7:0][WEIGHT_WIDTH-1:0]          shadow_q, shadow_d;
    logic [7:0][WEIGHT_WIDTH-1:0]          active_q, active_d;

    logic all_v;
    logic pipe_ce;
    logic fire;
    logic last_fire;
    logic bad_fire;
    logic frame_idle;
    logic swap;

    assign all_v      = &s_tvalid_i;
    assign pipe_ce    = !(vld_q[ADD_LAT-1] && !m_tready_i);
    assign fire       = (state_q == RUN) && pipe_ce && all_v;
    assign last_fire  = fire && (&s_tlast_i);
    // Mixed tlast across lanes: frame boundary is ambiguous, so the beat closes the frame and flags an error.
    assign bad_fire   = fire && (|s_tlast_i) && !(&s_tlast_i);
    assign frame_idle = (beat_cnt_q == '0) && !fire;
    assign swap       = commit_pend_q && (last_fire || (state_q != RUN) || frame_idle);

    always_comb begin
        state_d       = state_q;
        vld_d         = vld_q;
        lst_d         = lst_q;
        beat_cnt_d    = beat_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        err_d         = err_q;
        commit_pend_d = commit_pend_q;
        wt_loaded_d   = wt_loaded_q;
        shadow_d      = shadow_q;
        active_d      = active_q;

        case (state_q)
            IDLE: if (en_i && wt_loaded_q) state_d = RUN;
            RUN: begin
                if (bad_fire)
                    state_d = ERR;
                else if (!en_i && (last_fire || frame_idle))
                    state_d = IDLE;
            end
            ERR: if (err_clr_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pipe_ce) begin
            vld_d[0] = fire;
            lst_d[0] = fire && (|s_tlast_i);
            for (int k = 1; k < ADD_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                lst_d[k] = lst_q[k-1];
            end
        end

        if (last_fire) begin
            beat_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end else if (bad_fire) begin
            beat_cnt_d = '0;
        end else if (fire && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end

        if (bad_fire)
            err_d = 1'b1;
        else if (err_clr_i)
            err_d = 1'b0;

        // Swap reads the pre-write shadow; a same-cycle commit keeps the request pending.
        if (swap) begin
            active_d      = shadow_q;
            commit_pend_d = 1'b0;
            wt_loaded_d   = 1'b1;
        end
        if (cfg_commit_i)
            commit_pend_d = 1'b1;
        if (cfg_wr_i)
            shadow_d[cfg_addr_i] = cfg_data_i;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            vld_q         <= '0;
            lst_q         <= '0;
            beat_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            err_q         <= 1'b0;
            commit_pend_q <= 1'b0;
            wt_loaded_q   <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
        end else begin
            state_q       <= state_d;
            vld_q         <= vld_d;
            lst_q         <= lst_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            err_q         <= err_d;
            commit_pend_q <= commit_pend_d;
            wt_loaded_q   <= wt_loaded_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    assign s_tready_o    = {4{fire}};
    assign sum_fire_o    = fire;
    assign pipe_ce_o     = pipe_ce;
    assign m_tvalid_o    = vld_q[ADD_LAT-1];
    assign m_tlast_o     = lst_q[ADD_LAT-1];
    assign w_active_o    = active_q;
    assign commit_pend_o = commit_pend_q;
    assign err_o         = err_q;
    assign beat_cnt_o    = beat_cnt_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule
